// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : audio_pkg
//  Description : Shared audio-path constants, detector state type and a small
//                arithmetic helper. Used by the PDM capture path and by the
//                tone-output blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

    localparam int SYS_FREQ_HZ          = 100_000_000;
    localparam int MHZ                  = 1_000_000;
    localparam int MIC_HALF_DIV_DEFAULT = 20;    // 2.5 MHz micClk at 100 MHz
    localparam int DECIM_DEFAULT        = 128;   // PDM bits per output sample

    typedef enum logic [0:0] {
        DET_QUIET = 1'b0,
        DET_HOLD  = 1'b1
    } det_state_t;

    // Unsigned distance between two 8-bit values.
    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_clock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_clock_gen
//  Description : Divides clk down to the microphone clock and produces the
//                one-cycle capture strobe in the last clk of each micClk high
//                phase.
//  Ports       : clk, reset (async, active-high), en (run enable)
//                micClk  - clock to the microphone, low while disabled
//                capture - strobe: take the synchronized PDM bit this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module pdm_clock_gen #(
    parameter int HALF_DIV = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic micClk,
    output logic capture
);

    localparam int            CW   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(HALF_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          terminal;

    assign terminal = (div_cnt == TERM);

    // Disabling parks the divider at zero with micClk low, so every enable
    // starts a fresh low half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            micClk  <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            micClk  <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            micClk  <= ~micClk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Last cycle of the high phase: data has been stable for a full half
    // period plus synchronizer latency. Gating with en drops a capture that
    // coincides with disable.
    assign capture = en & micClk & terminal;

endmodule
`default_nettype wire

// File: rtl/mic_pdm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : mic_pdm_capture
//  Description : PDM microphone front end. Generates micClk, synchronizes and
//                counts PDM ones over DECIM-bit windows, reports the count and
//                its distance from mid-scale, and flags loud sounds with a
//                holdoff of HOLDOFF samples after each flag.
//  Ports       : clk, reset (async, active-high), en (capture enable)
//                micData      - PDM bit stream from the microphone (async)
//                micClk       - microphone clock
//                chSel        - microphone channel select, tied low
//                sample       - ones count of the last complete window
//                sample_valid - one-cycle strobe with each new sample
//                magnitude    - |sample - DECIM/2|
//                flap         - one-cycle strobe, loud sound detected
//  Revision    : 1.0  initial release
// ============================================================================
module mic_pdm_capture
    import audio_pkg::*;
#(
    parameter int SYS_FREQ     = SYS_FREQ_HZ,
    parameter int MIC_HALF_DIV = MIC_HALF_DIV_DEFAULT,
    parameter int DECIM        = DECIM_DEFAULT,
    parameter int THRESH       = 40,
    parameter int HOLDOFF      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       micData,
    output logic       micClk,
    output logic       chSel,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic [6:0] magnitude,
    output logic       flap
);

    // ---------------------------------------------------------------- checks
    if (DECIM < 16 || DECIM > 128 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("mic_pdm_capture: DECIM must be a power of two in 16..128");
    end
    if (SYS_FREQ / (2 * MIC_HALF_DIV) > 4_800_000) begin : g_mic_clk_too_fast
        $error("mic_pdm_capture: micClk above 4.8 MHz");
    end

    localparam int             BW       = $clog2(DECIM);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DECIM - 1);
    localparam logic [7:0]     MID      = 8'(DECIM / 2);
    localparam int             HW       = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HW-1:0]  HOLD_INIT = HW'(HOLDOFF);
    localparam logic [6:0]     THRESH7  = 7'(THRESH);

    assign chSel = 1'b0;   // left channel: mic drives data for the high phase

    // ------------------------------------------------------ clock generation
    logic capture;

    pdm_clock_gen #(
        .HALF_DIV (MIC_HALF_DIV)
    ) u_clock_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .micClk  (micClk),
        .capture (capture)
    );

    // ---------------------------------------------------------- synchronizer
    logic sync1, sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else if (!en) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= micData;
            sync2 <= sync1;
        end
    end

    // ----------------------------------------------------------- accumulator
    logic [7:0]    ones;
    logic [BW-1:0] bit_cnt;
    logic [7:0]    ones_next;

    // Count including the bit being captured now; 8 bits holds DECIM=128.
    assign ones_next = ones + {7'd0, sync2};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones         <= '0;
            bit_cnt      <= '0;
            sample       <= '0;
            magnitude    <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!en) begin
                // Partial window is thrown away; sample/magnitude keep value.
                ones    <= '0;
                bit_cnt <= '0;
            end else if (capture) begin
                if (bit_cnt == LAST_BIT) begin
                    sample       <= ones_next;
                    magnitude    <= 7'(abs_diff8(ones_next, MID));
                    sample_valid <= 1'b1;
                    ones         <= '0;
                    bit_cnt      <= '0;
                end else begin
                    ones    <= ones_next;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------- detector
    det_state_t    state;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= DET_QUIET;
            hold_cnt <= '0;
            flap     <= 1'b0;
        end else begin
            flap <= 1'b0;
            if (en && sample_valid) begin
                case (state)
                    DET_QUIET: begin
                        if (magnitude >= THRESH7) begin
                            flap <= 1'b1;
                            if (HOLDOFF > 0) begin
                                state    <= DET_HOLD;
                                hold_cnt <= HOLD_INIT;
                            end
                        end
                    end
                    DET_HOLD: begin
                        // The sample that brings the count to zero is
                        // consumed here and never evaluated.
                        hold_cnt <= hold_cnt - 1'b1;
                        if (hold_cnt == HW'(1)) begin
                            state <= DET_QUIET;
                        end
                    end
                    default: state <= DET_QUIET;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mic_pdm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mic_pdm_capture
//  Description : Randomized self-checking bench for mic_pdm_capture. A model
//                counts ones per window, derives magnitude and the
//                flag/ignore-next-N-samples behaviour, and is compared against
//                the DUT at every falling clk edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mic_pdm_capture;

    localparam int HALF    = 20;
    localparam int PERIOD  = 2 * HALF;
    localparam int DECIM   = 128;
    localparam int THRESH  = 40;
    localparam int HOLDOFF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       micData;
    logic       micClk;
    logic       chSel;
    logic [7:0] sample;
    logic       sample_valid;
    logic [6:0] magnitude;
    logic       flap;

    mic_pdm_capture #(
        .MIC_HALF_DIV (HALF),
        .DECIM        (DECIM),
        .THRESH       (THRESH),
        .HOLDOFF      (HOLDOFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .micData      (micData),
        .micClk       (micClk),
        .chSel        (chSel),
        .sample       (sample),
        .sample_valid (sample_valid),
        .magnitude    (magnitude),
        .flap         (flap)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         bits[$];
    int         win_ones;
    int         win_len;
    int         exp_sample;
    int         exp_mag;
    int         ignore_left;
    bit         flap_pend;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        win_ones    = 0;
        win_len     = 0;
        exp_sample  = 0;
        exp_mag     = 0;
        ignore_left = 0;
        flap_pend   = 1'b0;
    endtask

    // One PDM bit captured; returns 1 when it completes a window.
    function automatic bit model_capture(input bit b);
        win_ones += int'(b);
        win_len++;
        if (win_len < DECIM) return 1'b0;
        exp_sample = win_ones;
        exp_mag    = (win_ones >= DECIM / 2) ? win_ones - DECIM / 2 : DECIM / 2 - win_ones;
        win_ones   = 0;
        win_len    = 0;
        if (ignore_left > 0) begin
            ignore_left--;
        end else if (exp_mag >= THRESH) begin
            flap_pend   = 1'b1;
            ignore_left = HOLDOFF;
        end
        return 1'b1;
    endfunction

    task automatic check_outputs(input bit exp_clk, input bit exp_valid, input bit exp_flap);
        check("micClk", int'(micClk), int'(exp_clk));
        check("sample_valid", int'(sample_valid), int'(exp_valid));
        check("flap", int'(flap), int'(exp_flap));
        check("sample", int'(sample), exp_sample);
        check("magnitude", int'(magnitude), exp_mag);
    endtask

    // Idle cycles with capture disabled.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bit ef;
            @(negedge clk);
            ef = flap_pend;
            flap_pend = 1'b0;
            check_outputs(1'b0, 1'b0, ef);
        end
    endtask

    task automatic stop();
        en       = 1'b0;
        win_ones = 0;
        win_len  = 0;
        idle(1);
    endtask

    // Enables capture and plays the queued bits, one per micClk period.
    // The last bit lasts last_len clk; fewer than PERIOD means it is never
    // captured because the caller disables right before its capture edge.
    task automatic play(input int last_len);
        int n;
        n  = bits.size();
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            int len;
            len     = (i == n - 1) ? last_len : PERIOD;
            micData = bits[i];
            for (int j = 1; j <= len; j++) begin
                bit ef, ev;
                @(negedge clk);
                ef = flap_pend;
                flap_pend = 1'b0;
                ev = 1'b0;
                if (j == PERIOD) ev = model_capture(bits[i]);
                check_outputs((j >= HALF) && (j < PERIOD), ev, ef);
            end
        end
        if (last_len == PERIOD) begin
            bit ef;
            @(negedge clk);
            ef = flap_pend;
            flap_pend = 1'b0;
            check_outputs(1'b0, 1'b0, ef);
        end
        bits.delete();
    endtask

    task automatic gen_const(input bit v, input int n);
        for (int i = 0; i < n; i++) bits.push_back(v);
    endtask

    task automatic gen_alt(input int n);
        for (int i = 0; i < n; i++) bits.push_back(i % 2 == 0);
    endtask

    task automatic gen_random(input int n);
        for (int i = 0; i < n; i++) bits.push_back(bit'($urandom_range(1, 0)));
    endtask

    // One window with exactly k ones at random positions.
    task automatic gen_density(input int k);
        bit w[DECIM];
        for (int i = 0; i < DECIM; i++) w[i] = (i < k);
        for (int i = DECIM - 1; i > 0; i--) begin
            int r;
            bit t;
            r    = int'($urandom_range(i, 0));
            t    = w[i];
            w[i] = w[r];
            w[r] = t;
        end
        for (int i = 0; i < DECIM; i++) bits.push_back(w[i]);
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        micData = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_micClk", int'(micClk), 0);
        check("reset_sample", int'(sample), 0);
        check("reset_magnitude", int'(magnitude), 0);
        check("reset_valid", int'(sample_valid), 0);
        check("reset_flap", int'(flap), 0);
        check("chSel", int'(chSel), 0);
        reset = 1'b0;
        idle(2);

        // Loud constant stream: flag, ignore HOLDOFF samples, flag again.
        gen_const(1'b1, 4 * DECIM);
        play(PERIOD);
        check("ones_sample", int'(sample), 128);
        check("ones_magnitude", int'(magnitude), 64);

        // Asynchronous reset while the detector is holding off.
        #2 reset = 1'b1;
        #1;
        check("arst_micClk", int'(micClk), 0);
        check("arst_sample", int'(sample), 0);
        check("arst_magnitude", int'(magnitude), 0);
        check("arst_valid", int'(sample_valid), 0);
        check("arst_flap", int'(flap), 0);
        en      = 1'b0;
        micData = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle(2);

        // Density 108/128 right after reset must flag.
        gen_density(108);
        play(PERIOD);
        check("d108_magnitude", int'(magnitude), 44);
        stop();

        // Alternating, then two 100/128 windows; the last is evaluated quiet.
        gen_alt(DECIM);
        gen_density(100);
        gen_density(100);
        play(PERIOD);
        check("d100_magnitude", int'(magnitude), 36);
        stop();

        // Disable after 70 bits, long pause, then one full window.
        gen_random(70);
        play(PERIOD);
        stop();
        idle(1000);
        gen_random(DECIM);
        play(PERIOD);
        stop();

        // Disable exactly on the window-completing capture.
        gen_random(DECIM);
        play(PERIOD - 1);
        stop();
        idle(60);

        check("final_chSel", int'(chSel), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
